// File: rtl/game_flow_pkg.sv
// Shared types for the game flow controller: FSM states, screen codes, level index width.
package game_flow_pkg;

    localparam int unsigned LevelW = 3;

    typedef logic [LevelW-1:0] level_t;

    typedef enum logic [2:0] {
        StTitle,
        StLoad,
        StPlay,
        StResult,
        StEnd
    } state_e;

    localparam logic [1:0] ScreenTitle  = 2'd0;
    localparam logic [1:0] ScreenPlay   = 2'd1;
    localparam logic [1:0] ScreenResult = 2'd2;
    localparam logic [1:0] ScreenEnd    = 2'd3;

    // LOAD shows the play screen so the display is ready before the datapath starts.
    function automatic logic [1:0] screen_of(state_e s);
        logic [1:0] sel;
        sel = ScreenTitle;
        unique case (s)
            StTitle:  sel = ScreenTitle;
            StLoad:   sel = ScreenPlay;
            StPlay:   sel = ScreenPlay;
            StResult: sel = ScreenResult;
            StEnd:    sel = ScreenEnd;
            default:  sel = ScreenTitle;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Pushbutton press detector: one-cycle pulse on a 0->1 transition of a synchronous level.
module rising_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;
    logic armed_q;

    // armed_q stays low until the key has been seen released once after reset,
    // so a key held through reset release never yields a press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= level_i;
            armed_q <= armed_q | ~level_i;
        end
    end

    assign rise_o = level_i & ~prev_q & armed_q;

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencing FSM: title, level load, play, timed result screen and end screen.
module game_flow_controller
    import game_flow_pkg::*;
#(
    parameter int unsigned NUM_LEVELS  = 4,
    parameter int unsigned SCREEN_SECS = 3
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startKey,
    input  logic        oneSecPulse,
    input  logic        startOfFrame,
    input  logic        stageEnded,
    input  logic        stageFailed,
    output logic        levelEnable,
    output logic        cycleLevel,
    output logic [2:0]  levelIndex,
    output logic [1:0]  screenSel,
    output logic        resultWin,
    output logic        gameOver
);

    localparam level_t     LastLevel  = level_t'(NUM_LEVELS - 1);
    localparam logic [3:0] ScreenInit = 4'(SCREEN_SECS);

    state_e     state_q, state_d;
    logic       level_enable_q, level_enable_d;
    logic       cycle_level_q, cycle_level_d;
    level_t     level_index_q, level_index_d;
    logic [1:0] screen_sel_q, screen_sel_d;
    logic       result_win_q, result_win_d;
    logic       game_over_q, game_over_d;
    logic [3:0] count_q, count_d;
    logic       entry_q, entry_d;
    logic       press;

    rising_edge_detect u_press (
        .clk_i   (clk),
        .rst_ni  (resetN),
        .level_i (startKey),
        .rise_o  (press)
    );

    always_comb begin
        state_d       = state_q;
        cycle_level_d = 1'b0;
        level_index_d = level_index_q;
        result_win_d  = result_win_q;
        game_over_d   = game_over_q;
        count_d       = count_q;
        entry_d       = 1'b0;

        unique case (state_q)
            StTitle: begin
                if (press) begin
                    level_index_d = '0;
                    result_win_d  = 1'b0;
                    game_over_d   = 1'b0;
                    state_d       = StLoad;
                end
            end
            StLoad: begin
                if (startOfFrame) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (stageEnded) begin
                    result_win_d = ~stageFailed;
                    count_d      = ScreenInit;
                    entry_d      = 1'b1;
                    state_d      = StResult;
                end
            end
            StResult: begin
                // entry_q masks the first RESULT cycle so a tick coinciding with entry is dropped.
                if (press || (!entry_q && count_q == 4'd0)) begin
                    count_d = 4'd0;
                    if (!result_win_q) begin
                        game_over_d = 1'b1;
                        state_d     = StEnd;
                    end else if (level_index_q < LastLevel) begin
                        cycle_level_d = 1'b1;
                        level_index_d = level_index_q + level_t'(1);
                        state_d       = StLoad;
                    end else begin
                        game_over_d = 1'b0;
                        state_d     = StEnd;
                    end
                end else if (oneSecPulse && !entry_q && count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end
            end
            StEnd: begin
                if (press) begin
                    game_over_d = 1'b0;
                    state_d     = StTitle;
                end
            end
            default: state_d = StTitle;
        endcase

        level_enable_d = (state_d == StPlay);
        screen_sel_d   = screen_of(state_d);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= StTitle;
            level_enable_q <= 1'b0;
            cycle_level_q  <= 1'b0;
            level_index_q  <= '0;
            screen_sel_q   <= ScreenTitle;
            result_win_q   <= 1'b0;
            game_over_q    <= 1'b0;
            count_q        <= 4'd0;
            entry_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_enable_q <= level_enable_d;
            cycle_level_q  <= cycle_level_d;
            level_index_q  <= level_index_d;
            screen_sel_q   <= screen_sel_d;
            result_win_q   <= result_win_d;
            game_over_q    <= game_over_d;
            count_q        <= count_d;
            entry_q        <= entry_d;
        end
    end

    assign levelEnable = level_enable_q;
    assign cycleLevel  = cycle_level_q;
    assign levelIndex  = level_index_q;
    assign screenSel   = screen_sel_q;
    assign resultWin   = result_win_q;
    assign gameOver    = game_over_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench: a 4-level and a 2-level controller driven by the same stimulus.
module tb_game_flow_controller;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startKey = 1'b0;
    logic oneSecPulse = 1'b0;
    logic startOfFrame = 1'b0;
    logic stageEnded = 1'b0;
    logic stageFailed = 1'b0;

    logic       le4, cl4, rw4, go4;
    logic [2:0] li4;
    logic [1:0] ss4;
    logic       le2, cl2, rw2, go2;
    logic [2:0] li2;
    logic [1:0] ss2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    game_flow_controller #(.NUM_LEVELS(4), .SCREEN_SECS(3)) dut4 (
        .clk          (clk),
        .resetN       (resetN),
        .startKey     (startKey),
        .oneSecPulse  (oneSecPulse),
        .startOfFrame (startOfFrame),
        .stageEnded   (stageEnded),
        .stageFailed  (stageFailed),
        .levelEnable  (le4),
        .cycleLevel   (cl4),
        .levelIndex   (li4),
        .screenSel    (ss4),
        .resultWin    (rw4),
        .gameOver     (go4)
    );

    game_flow_controller #(.NUM_LEVELS(2), .SCREEN_SECS(3)) dut2 (
        .clk          (clk),
        .resetN       (resetN),
        .startKey     (startKey),
        .oneSecPulse  (oneSecPulse),
        .startOfFrame (startOfFrame),
        .stageEnded   (stageEnded),
        .stageFailed  (stageFailed),
        .levelEnable  (le2),
        .cycleLevel   (cl2),
        .levelIndex   (li2),
        .screenSel    (ss2),
        .resultWin    (rw2),
        .gameOver     (go2)
    );

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        // Reset held with key pressed: outputs zero, no press on release.
        startKey = 1'b1;
        cyc(3);
        chk("rst_le", {7'd0, le4}, 8'd0);
        chk("rst_cl", {7'd0, cl4}, 8'd0);
        chk("rst_li", {5'd0, li4}, 8'd0);
        chk("rst_ss", {6'd0, ss4}, 8'd0);
        chk("rst_rw", {7'd0, rw4}, 8'd0);
        chk("rst_go", {7'd0, go4}, 8'd0);
        resetN = 1'b1;
        cyc(3);
        chk("held_through_reset_no_press", {6'd0, ss4}, 8'd0);
        startKey = 1'b0;
        cyc();

        // Press and keep holding for over 100 cycles.
        startKey = 1'b1;
        cyc();
        chk("press_to_load_ss", {6'd0, ss4}, 8'd1);
        chk("press_to_load_le", {7'd0, le4}, 8'd0);
        cyc(4);
        chk("load_waits_sof", {7'd0, le4}, 8'd0);
        startOfFrame = 1'b1;
        cyc();
        startOfFrame = 1'b0;
        chk("play_le", {7'd0, le4}, 8'd1);
        chk("play_ss", {6'd0, ss4}, 8'd1);
        chk("play_li", {5'd0, li4}, 8'd0);
        cyc(80);
        chk("play_held_key", {7'd0, le4}, 8'd1);

        // Stage won; ticks on the ending cycle and first RESULT cycle are dropped.
        stageEnded  = 1'b1;
        stageFailed = 1'b0;
        oneSecPulse = 1'b1;
        cyc();
        stageEnded = 1'b0;
        chk("result_ss", {6'd0, ss4}, 8'd2);
        chk("result_win", {7'd0, rw4}, 8'd1);
        chk("result_le_drop", {7'd0, le4}, 8'd0);
        cyc();
        oneSecPulse = 1'b0;
        cyc(10);
        chk("result_held_key_no_exit", {6'd0, ss4}, 8'd2);
        for (int i = 0; i < 3; i++) begin
            oneSecPulse = 1'b1;
            cyc();
            oneSecPulse = 1'b0;
            chk("countdown_still_result", {6'd0, ss4}, 8'd2);
            if (i < 2) cyc();
        end
        chk("no_early_cycle", {7'd0, cl4}, 8'd0);
        cyc();
        chk("cycle_pulse", {7'd0, cl4}, 8'd1);
        chk("cycle_li", {5'd0, li4}, 8'd1);
        chk("cycle_load_ss", {6'd0, ss4}, 8'd1);
        chk("cycle_load_le", {7'd0, le4}, 8'd0);
        chk("cycle_pulse_2lv", {7'd0, cl2}, 8'd1);
        cyc();
        chk("cycle_one_cycle", {7'd0, cl4}, 8'd0);
        startKey = 1'b0;
        cyc();

        // Level 1 won and exited by a press: 4-level advances, 2-level ends.
        startOfFrame = 1'b1;
        cyc();
        startOfFrame = 1'b0;
        chk("lv1_play", {7'd0, le4}, 8'd1);
        stageEnded = 1'b1;
        cyc();
        stageEnded = 1'b0;
        cyc(2);
        startKey = 1'b1;
        cyc();
        startKey = 1'b0;
        chk("lv1_exit_cl4", {7'd0, cl4}, 8'd1);
        chk("lv1_exit_li4", {5'd0, li4}, 8'd2);
        chk("end2_ss", {6'd0, ss2}, 8'd3);
        chk("end2_go", {7'd0, go2}, 8'd0);
        chk("end2_li", {5'd0, li2}, 8'd1);
        chk("end2_no_cycle", {7'd0, cl2}, 8'd0);
        cyc();
        chk("end2_no_cycle_later", {7'd0, cl2}, 8'd0);

        // Level 2 playing, then asynchronous reset mid-PLAY.
        startOfFrame = 1'b1;
        cyc();
        startOfFrame = 1'b0;
        cyc(3);
        chk("lv2_play_le", {7'd0, le4}, 8'd1);
        chk("lv2_play_li", {5'd0, li4}, 8'd2);
        resetN = 1'b0;
        #1;
        chk("async_rst_le", {7'd0, le4}, 8'd0);
        chk("async_rst_li", {5'd0, li4}, 8'd0);
        chk("async_rst_ss", {6'd0, ss4}, 8'd0);
        chk("async_rst_rw", {7'd0, rw4}, 8'd0);
        chk("async_rst_go", {7'd0, go4}, 8'd0);
        chk("async_rst_ss2", {6'd0, ss2}, 8'd0);
        cyc(2);
        resetN = 1'b1;
        cyc(2);

        // Loss path; stageEnded in LOAD must be ignored.
        startKey = 1'b1;
        cyc();
        startKey = 1'b0;
        chk("loss_load", {6'd0, ss4}, 8'd1);
        stageEnded  = 1'b1;
        stageFailed = 1'b1;
        cyc();
        stageEnded = 1'b0;
        chk("ended_in_load_ignored", {6'd0, ss4}, 8'd1);
        chk("ended_in_load_le", {7'd0, le4}, 8'd0);
        startOfFrame = 1'b1;
        cyc();
        startOfFrame = 1'b0;
        chk("loss_play", {7'd0, le4}, 8'd1);
        stageEnded = 1'b1;
        cyc();
        stageEnded  = 1'b0;
        stageFailed = 1'b0;
        chk("loss_result_ss", {6'd0, ss4}, 8'd2);
        chk("loss_result_win", {7'd0, rw4}, 8'd0);
        cyc();
        startKey = 1'b1;
        cyc();
        startKey = 1'b0;
        chk("loss_end_ss", {6'd0, ss4}, 8'd3);
        chk("loss_end_go", {7'd0, go4}, 8'd1);
        chk("loss_end_cl", {7'd0, cl4}, 8'd0);
        cyc(2);
        startKey = 1'b1;
        cyc();
        startKey = 1'b0;
        chk("end_to_title_ss", {6'd0, ss4}, 8'd0);
        chk("end_to_title_li", {5'd0, li4}, 8'd0);
        chk("end_to_title_go", {7'd0, go4}, 8'd0);
        cyc(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/game_flow_controller.md
GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 SHALL have parameter NUM_LEVELS, default 4, meaning the number of playable stages (1..8).
REQ-002 SHALL have parameter SCREEN_SECS, default 3, meaning the result-screen hold time in oneSecPulse ticks (1..15).
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port startKey, input, 1, active-high pushbutton level, already synchronous to clk.
REQ-006 SHALL have port oneSecPulse, input, 1, one-cycle tick once per second.
REQ-007 SHALL have port startOfFrame, input, 1, one-cycle pulse at frame start.
REQ-008 SHALL have port stageEnded, input, 1, one-cycle pulse from the stage datapath marking stage completion.
REQ-009 SHALL have port stageFailed, input, 1, stage outcome, valid only in the cycle stageEnded is high.
REQ-010 SHALL have port levelEnable, output, 1, high while the stage datapath runs.
REQ-011 SHALL have port cycleLevel, output, 1, one-cycle pulse advancing the stage datapath to the next level.
REQ-012 SHALL have port levelIndex, output, 3, current stage number, 0-based.
REQ-013 SHALL have port screenSel, output, 2, screen selector: 0 title, 1 play, 2 result, 3 end.
REQ-014 SHALL have port resultWin, output, 1, outcome of the last stage (1 = passed).
REQ-015 SHALL have port gameOver, output, 1, high in END when the game was lost.

Function
REQ-016 SHALL implement FSM states TITLE, LOAD, PLAY, RESULT, END, with all outputs registered.
REQ-017 SHALL define a key press as a startKey rising edge (0 in the previous cycle, 1 now); a held key generates exactly one press.
REQ-018 TITLE: levelEnable=0, screenSel=0; a press SHALL clear levelIndex, resultWin and gameOver, then go to LOAD.
REQ-019 LOAD: levelEnable=0; at the first startOfFrame it SHALL go to PLAY, and levelEnable SHALL rise in the cycle after that startOfFrame.
REQ-020 PLAY: levelEnable=1, screenSel=1; presses ignored; on stageEnded it SHALL latch resultWin=!stageFailed, drop levelEnable next cycle and go to RESULT.
REQ-021 RESULT: screenSel=2; a 4-bit countdown SHALL load SCREEN_SECS on entry and decrement per oneSecPulse; a pulse in the entry cycle is not counted.
REQ-022 RESULT exit SHALL occur at countdown 0 or on a press, whichever is first.
REQ-023 On RESULT exit with win and levelIndex<NUM_LEVELS-1, the block SHALL pulse cycleLevel for exactly 1 cycle, increment levelIndex in the same cycle, and go to LOAD.
REQ-024 On RESULT exit with win and levelIndex==NUM_LEVELS-1, the block SHALL go to END with gameOver=0 and hold levelIndex (no wrap).
REQ-025 On RESULT exit after a loss, the block SHALL go to END with gameOver=1.
REQ-026 END: screenSel=3; a press SHALL go to TITLE.
REQ-027 stageEnded outside PLAY SHALL be ignored.
REQ-028 The press edge detector SHALL keep updating in every state, so a key held across a state change does not count as a new press.

Reset
REQ-029 resetN low SHALL force TITLE, levelEnable=0, cycleLevel=0, levelIndex=0, screenSel=0, resultWin=0, gameOver=0, countdown=0 and previous-key=0, at any time including mid-PLAY.
REQ-030 After resetN release, the first press SHALL require startKey observed low for at least one cycle.

Structure
REQ-031 Package game_flow_pkg SHALL hold the state enum, the screenSel encodings and the 3-bit level-index width.
REQ-032 The press edge detector SHALL be a sub-module named rising_edge_detect.

Verification
REQ-033 Reset, press, then startOfFrame 5 cycles later -> levelEnable=1 from cycle 6, screenSel=1, levelIndex=0.
REQ-034 In PLAY, stageEnded with stageFailed=0, then 3 oneSecPulse -> RESULT with resultWin=1, then cycleLevel 1-cycle pulse, levelIndex=1, state LOAD.
REQ-035 NUM_LEVELS=2, both stages won -> END, gameOver=0, levelIndex=1, cycleLevel never pulses after stage 1.
REQ-036 stageEnded with stageFailed=1 at level 0, then press during RESULT -> immediate END, gameOver=1; next press -> TITLE, levelIndex=0.
REQ-037 startKey held high for 100 cycles through TITLE->LOAD -> exactly one press; oneSecPulse in the RESULT entry cycle is not counted.
REQ-038 resetN pulsed low mid-PLAY at levelIndex=2 -> all outputs zero within the same cycle and state TITLE.
